fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end: owns the architectural PC register and issues single-word reads to instruction memory.
- Presents each fetched instruction and its PC to decode/execute.
- Consumes the next-PC and instruction-misalignment result produced by the execute stage's PC calculator at retire time.
- Also provides redirect (trap/debug entry) and halt/resume hooks for the debug module.

Parameters:
- Width, 32, address/data width in bits.
- ResetVector, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- mem_req  out  1  read request; held until accepted.
- mem_addr  out  Width  read address, equal to pc.
- mem_ack  in  1  read completes this cycle; valid only while mem_req=1, and may be high in the same cycle mem_req rises.
- mem_rdata  in  Width  read data, valid when mem_req&&mem_ack.
- inst  out  Width  fetched instruction.
- inst_pc  out  Width  PC of inst.
- inst_valid  out  1  inst/inst_pc valid.
- retire  in  1  execute consumed inst; next_pc/ialign are valid.
- next_pc  in  Width  PC of the following instruction.
- ialign  in  1  next_pc is misaligned.
- fault_ialign  out  1  sticky misaligned-fetch fault.
- fault_addr  out  Width  offending next_pc.
- redirect  in  1  force fetch from redirect_pc (trap/debug entry).
- redirect_pc  in  Width  redirect target; bit0 is ignored and treated as 0.
- halt_req  in  1  debug halt request, level.
- halted  out  1  fetch stopped at an instruction boundary.

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is synchronous, active-high, and overrides every other input.
- Reset values:
  - pc=ResetVector, state=FETCH.
  - mem_req=0, inst_valid=0, inst=0, inst_pc=0.
  - fault_ialign=0, fault_addr=0, halted=0.
- Outputs per state:
  - mem_req=1 only in FETCH.
  - mem_addr=pc at all times.
  - inst_valid=1 only in HOLD.
  - halted=1 only in HALTED.
- States: FETCH, HOLD, BUBBLE, HALTED, FAULT.
- FETCH:
  - mem_req=1.
  - On mem_ack: inst<=mem_rdata, inst_pc<=pc, go to HOLD.
  - mem_addr is stable while mem_req=1 and mem_ack=0.
- HOLD:
  - retire is ignored in every other state.
  - retire&&ialign: fault_ialign<=1, fault_addr<=next_pc, go to FAULT.
  - retire&&!ialign&&halt_req: pc<=next_pc, go to HALTED.
  - retire&&!ialign&&!halt_req: pc<=next_pc, go to FETCH.
  - Minimum retire-to-next-inst_valid latency is 2 cycles (FETCH with same-cycle ack, then HOLD).
- HALTED:
  - mem_req=0.
  - Leave to FETCH when halt_req=0.
  - pc is unchanged, so fetch resumes at the saved next_pc.
- FAULT:
  - mem_req=0, fault_ialign held.
  - Exited only by redirect or rst.
- BUBBLE:
  - Exactly one cycle with mem_req=0, then go to FETCH.
- Redirect, in any state:
  - Highest priority after rst.
  - pc<=redirect_pc with bit0 cleared; inst_valid<=0; fault_ialign<=0.
  - From FETCH: a mem_ack in that same cycle is discarded (inst not updated); go to BUBBLE, so the address never changes while a request is pending.
  - From HOLD, HALTED or FAULT: go directly to FETCH.
  - A retire in the same cycle as redirect is ignored.
  - Redirect while halt_req=1 still fetches; halt is re-evaluated at the next retire.
- halt_req rising outside HOLD takes effect at the next retire, so halting occurs only on an instruction boundary.
- Misaligned redirect_pc bit1 is not a fault here; the memory subsystem handles it.
- pc arithmetic: no internal adder; pc is loaded only from ResetVector, next_pc or redirect_pc. Wrap-around is inherited from the producer.

Test Plan:
- Straight-line fetch:
  - Stimulus: rst, mem_ack same-cycle, data 32'h00000013; retire with next_pc=inst_pc+4 each HOLD.
  - Response: mem_addr sequence 0,4,8,C; inst_valid every 2nd cycle; inst_pc matches.
- Wait states:
  - Stimulus: mem_ack delayed 3 cycles.
  - Response: mem_req high and mem_addr=0 stable for 4 cycles; inst_valid only after ack.
- Taken branch:
  - Stimulus: retire with next_pc=32'h0000_0100.
  - Response: next mem_addr=32'h100.
  - Stimulus: retire with next_pc=32'h102, ialign=1.
  - Response: fault_ialign=1, fault_addr=32'h102, mem_req stays 0 for 10 cycles.
- Redirect:
  - Stimulus: redirect to 32'h0000_0801 while in FETCH with mem_ack=1 in the same cycle.
  - Response: ack data dropped; one cycle mem_req=0; then mem_addr=32'h800; fault cleared.
- Debug halt:
  - Stimulus: halt_req=1 during HOLD at pc 32'h10; retire with next_pc=32'h14.
  - Response: halted=1, mem_req=0.
  - Stimulus: drop halt_req.
  - Response: mem_addr=32'h14 and fetch resumes.
- Reset mid-operation:
  - Stimulus: rst asserted in FETCH (pending), in HOLD and in FAULT.
  - Response: next cycle mem_req=0, inst_valid=0, fault_ialign=0, mem_addr=ResetVector.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the architectural PC, issues single-word
// reads, holds each fetched instruction until retire, and handles redirect/halt/fault.
module fetch_unit #(
  parameter int                Width       = 32,
  parameter logic [Width-1:0]  ResetVector = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic [Width-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [Width-1:0] mem_rdata,
  output logic [Width-1:0] inst,
  output logic [Width-1:0] inst_pc,
  output logic             inst_valid,
  input  logic             retire,
  input  logic [Width-1:0] next_pc,
  input  logic             ialign,
  output logic             fault_ialign,
  output logic [Width-1:0] fault_addr,
  input  logic             redirect,
  input  logic [Width-1:0] redirect_pc,
  input  logic             halt_req,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_HOLD   = 3'd1,
    S_BUBBLE = 3'd2,
    S_HALTED = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] inst_q, inst_d;
  logic [Width-1:0] inst_pc_q, inst_pc_d;
  logic             fault_ialign_q, fault_ialign_d;
  logic [Width-1:0] fault_addr_q, fault_addr_d;
  logic             mem_req_q, mem_req_d;
  logic             inst_valid_q, inst_valid_d;
  logic             halted_q, halted_d;

  function automatic logic [Width-1:0] clear_bit0(input logic [Width-1:0] a);
    return a & ~{{(Width-1){1'b0}}, 1'b1};
  endfunction

  // Next-state and datapath selection
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    fault_ialign_d = fault_ialign_q;
    fault_addr_d   = fault_addr_q;

    if (redirect) begin
      pc_d           = clear_bit0(redirect_pc);
      fault_ialign_d = 1'b0;
      // A pending request must see a stable address, so FETCH drains through BUBBLE.
      state_d        = (state_q == S_FETCH) ? S_BUBBLE : S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (mem_req_q && mem_ack) begin
            inst_d    = mem_rdata;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (retire) begin
            if (ialign) begin
              fault_ialign_d = 1'b1;
              fault_addr_d   = next_pc;
              state_d        = S_FAULT;
            end else begin
              pc_d    = next_pc;
              state_d = halt_req ? S_HALTED : S_FETCH;
            end
          end
        end
        S_BUBBLE: state_d = S_FETCH;
        S_HALTED: begin
          if (!halt_req) state_d = S_FETCH;
        end
        S_FAULT:  state_d = S_FAULT;
        default:  state_d = S_FETCH;
      endcase
    end

    // Outputs are registered from the next state so they start clean out of reset.
    mem_req_d    = (state_d == S_FETCH);
    inst_valid_d = (state_d == S_HOLD);
    halted_d     = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      pc_q           <= ResetVector;
      inst_q         <= '0;
      inst_pc_q      <= '0;
      fault_ialign_q <= 1'b0;
      fault_addr_q   <= '0;
      mem_req_q      <= 1'b0;
      inst_valid_q   <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      inst_pc_q      <= inst_pc_d;
      fault_ialign_q <= fault_ialign_d;
      fault_addr_q   <= fault_addr_d;
      mem_req_q      <= mem_req_d;
      inst_valid_q   <= inst_valid_d;
      halted_q       <= halted_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = pc_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign inst_valid   = inst_valid_q;
  assign fault_ialign = fault_ialign_q;
  assign fault_addr   = fault_addr_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: fetch, wait states, branch/fault,
// redirect, debug halt and mid-operation reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        retire;
  logic [31:0] next_pc;
  logic        ialign;
  logic        fault_ialign;
  logic [31:0] fault_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;

  int tests;
  int fails;

  fetch_unit #(.Width(32), .ResetVector(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .retire(retire), .next_pc(next_pc), .ialign(ialign),
    .fault_ialign(fault_ialign), .fault_addr(fault_addr),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; retire = 1'b0; next_pc = '0;
    ialign = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // From reset, reach FETCH with mem_req=1 at addr.
  task automatic goto_fetch_at(input logic [31:0] addr);
    do_reset();
    redirect = 1'b1; redirect_pc = addr;
    tick();
    redirect = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if ({mem_req, inst_valid, fault_ialign, halted} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, inst_valid, fault_ialign, halted}); end
    tests++; if ({inst, inst_pc, fault_addr, mem_addr} !== 128'h0) begin
      fails++; $display("FAIL reset_data: inst=%h inst_pc=%h fault_addr=%h addr=%h want all 0",
                        inst, inst_pc, fault_addr, mem_addr); end
    tick();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL reset_first_req: req=%b addr=%h want 1/0", mem_req, mem_addr); end
  endtask

  task automatic test_straight_line();
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i) || inst_valid !== 1'b0) begin
        fails++; $display("FAIL straight_fetch%0d: req=%b addr=%h vld=%b want 1/%h/0",
                          i, mem_req, mem_addr, inst_valid, 32'(4 * i)); end
      mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
      tick();
      mem_ack = 1'b0;
      tests++; if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'(4 * i) || mem_req !== 1'b0) begin
        fails++; $display("FAIL straight_hold%0d: vld=%b inst=%h pc=%h req=%b want 1/13/%h/0",
                          i, inst_valid, inst, inst_pc, mem_req, 32'(4 * i)); end
      retire = 1'b1; next_pc = 32'(4 * i + 4);
      tick();
      retire = 1'b0;
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    tick();
    // Retire outside HOLD must be ignored.
    retire = 1'b1; next_pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || inst_valid !== 1'b0) begin
        fails++; $display("FAIL wait_cycle%0d: req=%b addr=%h vld=%b want 1/0/0",
                          i, mem_req, mem_addr, inst_valid); end
      tick();
    end
    retire = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL wait_cycle3: req=%b addr=%h want 1/0", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hAABB_CCDD;
    tick();
    mem_ack = 1'b0;
    tests++; if (inst_valid !== 1'b1 || inst !== 32'hAABB_CCDD || inst_pc !== 32'h0) begin
      fails++; $display("FAIL wait_data: vld=%b inst=%h pc=%h want 1/aabbccdd/0", inst_valid, inst, inst_pc); end
  endtask

  // Continues from HOLD at inst_pc 0 left by test_wait_states.
  task automatic test_branch_fault();
    int bad;
    retire = 1'b1; next_pc = 32'h100;
    tick();
    retire = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      fails++; $display("FAIL branch_target: req=%b addr=%h want 1/100", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    retire = 1'b1; next_pc = 32'h102; ialign = 1'b1;
    tick();
    retire = 1'b0; ialign = 1'b0;
    tests++; if (fault_ialign !== 1'b1 || fault_addr !== 32'h102 || inst_valid !== 1'b0 || mem_addr !== 32'h100) begin
      fails++; $display("FAIL fault_entry: flt=%b faddr=%h vld=%b addr=%h want 1/102/0/100",
                        fault_ialign, fault_addr, inst_valid, mem_addr); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req !== 1'b0 || fault_ialign !== 1'b1) bad++;
      tick();
    end
    tests++; if (bad !== 0) begin
      fails++; $display("FAIL fault_hold: %0d bad cycles want 0", bad); end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || fault_ialign !== 1'b0) begin
      fails++; $display("FAIL fault_exit: req=%b addr=%h flt=%b want 1/200/0", mem_req, mem_addr, fault_ialign); end
  endtask

  // Continues from FETCH at 0x200; last accepted inst was 0x12345678.
  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h0000_0801; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h1234_5678) begin
      fails++; $display("FAIL redirect_drop: req=%b vld=%b inst=%h want 0/0/12345678", mem_req, inst_valid, inst); end
    tick();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h800 || fault_ialign !== 1'b0) begin
      fails++; $display("FAIL redirect_target: req=%b addr=%h flt=%b want 1/800/0", mem_req, mem_addr, fault_ialign); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0033;
    tick();
    mem_ack = 1'b0;
    // Redirect wins over a simultaneous misaligned retire.
    redirect = 1'b1; redirect_pc = 32'h900; retire = 1'b1; next_pc = 32'h804; ialign = 1'b1;
    tick();
    redirect = 1'b0; retire = 1'b0; ialign = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h900 || fault_ialign !== 1'b0) begin
      fails++; $display("FAIL redirect_vs_retire: req=%b addr=%h flt=%b want 1/900/0", mem_req, mem_addr, fault_ialign); end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; mem_rdata = 32'h13;
      tick();
      mem_ack = 1'b0; retire = 1'b1; next_pc = 32'(4 * i + 4);
      tick();
      retire = 1'b0;
    end
    halt_req = 1'b1;
    tick();
    tests++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      fails++; $display("FAIL halt_not_boundary: halted=%b req=%b addr=%h want 0/1/10", halted, mem_req, mem_addr); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || halted !== 1'b0) begin
      fails++; $display("FAIL halt_hold: vld=%b pc=%h halted=%b want 1/10/0", inst_valid, inst_pc, halted); end
    retire = 1'b1; next_pc = 32'h14;
    tick();
    retire = 1'b0;
    tests++; if (halted !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      fails++; $display("FAIL halt_enter: halted=%b req=%b vld=%b want 1/0/0", halted, mem_req, inst_valid); end
    tick();
    tests++; if (halted !== 1'b1 || mem_req !== 1'b0) begin
      fails++; $display("FAIL halt_stay: halted=%b req=%b want 1/0", halted, mem_req); end
    halt_req = 1'b0;
    tick();
    tests++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h14) begin
      fails++; $display("FAIL halt_resume: halted=%b req=%b addr=%h want 0/1/14", halted, mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
    tick();
    mem_ack = 1'b0;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h14 || inst !== 32'h93) begin
      fails++; $display("FAIL halt_refetch: vld=%b pc=%h inst=%h want 1/14/93", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_reset_mid();
    goto_fetch_at(32'h40);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || fault_ialign !== 1'b0 || mem_addr !== 32'h0 || inst !== 32'h0) begin
      fails++; $display("FAIL rst_in_fetch: req=%b vld=%b flt=%b addr=%h inst=%h want 0/0/0/0/0",
                        mem_req, inst_valid, fault_ialign, mem_addr, inst); end
    goto_fetch_at(32'h40);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || mem_addr !== 32'h0 || inst_pc !== 32'h0) begin
      fails++; $display("FAIL rst_in_hold: req=%b vld=%b addr=%h ipc=%h want 0/0/0/0",
                        mem_req, inst_valid, mem_addr, inst_pc); end
    goto_fetch_at(32'h40);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_ack = 1'b0; retire = 1'b1; next_pc = 32'h43; ialign = 1'b1;
    tick();
    retire = 1'b0; ialign = 1'b0;
    tests++; if (fault_ialign !== 1'b1 || fault_addr !== 32'h43) begin
      fails++; $display("FAIL rst_fault_setup: flt=%b faddr=%h want 1/43", fault_ialign, fault_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (mem_req !== 1'b0 || fault_ialign !== 1'b0 || fault_addr !== 32'h0 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL rst_in_fault: req=%b flt=%b faddr=%h addr=%h want 0/0/0/0",
                        mem_req, fault_ialign, fault_addr, mem_addr); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_straight_line();
    test_wait_states();
    test_branch_fault();
    test_redirect();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
